// File: rtl/sccb_init_seq_if.sv
// SCCB write-request bundle between the init sequencer and the SCCB write controller.
// Latency: none, wires only.
// Backpressure: the request side holds sccb_req/id/addr/data until sccb_ready is seen high.
//
// Signals:
//   sccb_req   - write request from the sequencer
//   sccb_ready - controller accepts a request on a cycle where req and ready are both high
//   sccb_id    - 8-bit device ID (non-zero only while a request is pending)
//   sccb_addr  - 8-bit register address
//   sccb_data  - 8-bit register value
//   sccb_done  - one-cycle pulse when the controller finishes the accepted write
// Modports: master = sequencer side, slave = SCCB controller side.
interface sccb_init_seq_if;
  logic       sccb_req;
  logic       sccb_ready;
  logic [7:0] sccb_id;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_data;
  logic       sccb_done;

  modport master (
    output sccb_req,
    output sccb_id,
    output sccb_addr,
    output sccb_data,
    input  sccb_ready,
    input  sccb_done
  );

  modport slave (
    input  sccb_req,
    input  sccb_id,
    input  sccb_addr,
    input  sccb_data,
    output sccb_ready,
    output sccb_done
  );
endinterface

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a fixed OV7670 register table and issues one SCCB write per entry.
// Latency: start -> sccb_req 2 cycles after the start edge; sccb_done -> next sccb_req 2 cycles.
// Backpressure: sccb_req/id/addr/data held until sccb_ready; the timeout only runs after accept.
//
// Ports:
//   xclk        - clock, all logic on the rising edge
//   rst_n       - asynchronous active-low reset
//   start       - one-cycle pulse, (re)runs the table from entry 0 when not busy
//   sccb        - request/ready/done bundle towards the SCCB write controller (master side)
//   busy        - sequence in progress
//   done        - table completed successfully, held until the next start
//   err         - a write timed out, held until the next start
//   entry_idx   - current table index (holds the failing entry on err)
//
// Build option SCCB_INIT_AUTOSTART_EN: when defined, the first edge after reset release acts
// as an internal start pulse so the camera is configured without an external start.
module sccb_init_seq #(
  parameter logic [7:0]  SLAVE_ID       = 8'h42,
  parameter logic [23:0] DELAY_CYCLES   = 24'd240000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic            xclk,
  input  logic            rst_n,
  input  logic            start,
  sccb_init_seq_if.master sccb,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      entry_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT,
    S_DELAY,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    K_WR,
    K_DLY,
    K_END
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  // Init table. Entry 0 is the COM7 soft reset; the sensor needs the settle
  // delay of entry 1 before it accepts further register writes.
  function automatic entry_t tbl(input logic [2:0] idx);
    entry_t e;
    e = '{kind: K_END, addr: 8'h00, data: 8'h00};
    case (idx)
      3'd0: e = '{kind: K_WR,  addr: 8'h12, data: 8'h80};
      3'd1: e = '{kind: K_DLY, addr: 8'h00, data: 8'h00};
      3'd2: e = '{kind: K_WR,  addr: 8'h12, data: 8'h14};
      3'd3: e = '{kind: K_WR,  addr: 8'h40, data: 8'hD0};
      3'd4: e = '{kind: K_WR,  addr: 8'h11, data: 8'h01};
      3'd5: e = '{kind: K_WR,  addr: 8'h3A, data: 8'h04};
      3'd6: e = '{kind: K_WR,  addr: 8'h8C, data: 8'h00};
      3'd7: e = '{kind: K_END, addr: 8'h00, data: 8'h00};
    endcase
    return e;
  endfunction

  state_t      state_q;
  logic [2:0]  idx_q;
  logic        req_q;
  logic [7:0]  id_q;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] tmo_q;
  logic [23:0] dly_q;

  entry_t      fetch_ent;
  logic        tmo_last;
  logic        dly_last;
  logic        start_go;

  assign fetch_ent = tbl(idx_q);

  // Terminal-count flags. The >= keeps the counters saturating even if a
  // parameter is set to 0, where the subtraction would otherwise wrap.
  assign tmo_last = (TIMEOUT_CYCLES == 16'd0) || (tmo_q >= (TIMEOUT_CYCLES - 16'd1));
  assign dly_last = (DELAY_CYCLES == 24'd0)   || (dly_q >= (DELAY_CYCLES - 24'd1));

`ifdef SCCB_INIT_AUTOSTART_EN
  // Set by reset, cleared on the first edge afterwards: a one-shot start.
  logic auto_q;

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= 1'b0;
    end
  end

  assign start_go = start | auto_q;
`else
  assign start_go = start;
`endif

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      req_q   <= 1'b0;
      id_q    <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 16'd0;
      dly_q   <= 24'd0;
    end else begin
      case (state_q)
        // start is only honoured when not busy; it also clears done/err.
        S_IDLE, S_DONE, S_ERR: begin
          if (start_go) begin
            state_q <= S_FETCH;
            idx_q   <= 3'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end

        S_FETCH: begin
          case (fetch_ent.kind)
            K_WR: begin
              addr_q  <= fetch_ent.addr;
              data_q  <= fetch_ent.data;
              state_q <= S_REQ;
            end
            K_DLY: begin
              dly_q   <= 24'd0;
              state_q <= S_DELAY;
            end
            default: begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          endcase
        end

        // First REQ cycle raises the registered request; addr/data were
        // already latched in FETCH so all request fields appear together.
        S_REQ: begin
          if (!req_q) begin
            req_q <= 1'b1;
            id_q  <= SLAVE_ID;
          end else if (sccb.sccb_ready) begin
            req_q   <= 1'b0;
            id_q    <= 8'h00;
            tmo_q   <= 16'd0;
            state_q <= S_WAIT;
          end
        end

        // done is tested first so it wins over a coincident expiry.
        S_WAIT: begin
          if (sccb.sccb_done) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= S_FETCH;
          end else if (tmo_last) begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end

        S_DELAY: begin
          if (dly_last) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= S_FETCH;
          end else begin
            dly_q <= dly_q + 24'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          id_q    <= 8'h00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sccb.sccb_req  = req_q;
  assign sccb.sccb_id   = id_q;
  assign sccb.sccb_addr = addr_q;
  assign sccb.sccb_data = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign entry_idx      = idx_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: an SCCB controller model with a write scoreboard plus directed runs
// covering normal sequencing, backpressure, timeout, done/timeout tie and reset mid-write.
module tb_sccb_init_seq;

`ifdef SCCB_INIT_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       xclk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] entry_idx;

  sccb_init_seq_if sif ();

  sccb_init_seq #(
    .SLAVE_ID       (8'h42),
    .DELAY_CYCLES   (24'd100),
    .TIMEOUT_CYCLES (16'd64)
  ) dut (
    .xclk      (xclk),
    .rst_n     (rst_n),
    .start     (start),
    .sccb      (sif),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .entry_idx (entry_idx)
  );

  wr_t exp_wr [0:5] = '{'{8'h12, 8'h80}, '{8'h12, 8'h14}, '{8'h40, 8'hD0},
                        '{8'h11, 8'h01}, '{8'h3A, 8'h04}, '{8'h8C, 8'h00}};

  wr_t sb_q [$];
  int  acc_cyc [$];
  int  acc_n    = 0;
  int  ncyc     = 0;
  int  n_chk    = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;

  // Controller model knobs.
  bit  bp       = 1'b0;
  bit  spur     = 1'b0;
  int  kill_no  = -1;
  int  done_lat = 20;

  initial begin
    xclk = 1'b0;
    forever #5 xclk = ~xclk;
  end

  always @(posedge xclk) ncyc <= ncyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge xclk);
    #1;
  endtask

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_wr[i]);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) tick();
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && !done && !err; i++) tick();
    chk(tag, done, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},  sif.sccb_req,  1'b0);
    chk({tag, "_id"},   sif.sccb_id,   8'h00);
    chk({tag, "_addr"}, sif.sccb_addr, 8'h00);
    chk({tag, "_data"}, sif.sccb_data, 8'h00);
    chk({tag, "_busy"}, busy,          1'b0);
    chk({tag, "_done"}, done,          1'b0);
    chk({tag, "_err"},  err,           1'b0);
    chk({tag, "_idx"},  entry_idx,     3'd0);
  endtask

  // SCCB controller model. Works on the falling edge: values it drives are
  // sampled by the DUT on the next rising edge, and req&&ready seen here
  // means the DUT accepts on that next rising edge.
  initial begin : ctrl_model
    int  hold;
    int  dcnt;
    bit  pend;
    hold = 0;
    dcnt = 0;
    pend = 1'b0;
    sif.sccb_ready = 1'b1;
    sif.sccb_done  = 1'b0;
    forever begin
      @(negedge xclk);
      sif.sccb_done = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        hold = 0;
      end else begin
        if (pend) begin
          dcnt--;
          if (dcnt <= 0) begin
            sif.sccb_done = 1'b1;
            pend          = 1'b0;
          end
        end
        if (sif.sccb_req) begin
          hold++;
          sif.sccb_ready = !bp || (hold >= 8);
          chk("req_expected", (sb_q.size() != 0), 1'b1);
          if (sb_q.size() != 0) begin
            chk("req_addr", sif.sccb_addr, sb_q[0].addr);
            chk("req_data", sif.sccb_data, sb_q[0].data);
            chk("req_id",   sif.sccb_id,   8'h42);
          end
          if (spur && !sif.sccb_ready && hold == 3) sif.sccb_done = 1'b1;
          if (sif.sccb_ready) begin
            acc_cyc.push_back(ncyc);
            if (acc_n != kill_no) begin
              pend = 1'b1;
              dcnt = done_lat;
            end
            acc_n++;
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            hold = 0;
          end
        end else begin
          hold = 0;
          sif.sccb_ready = !bp;
        end
      end
    end
  end

  initial begin : main_seq
    int d01;
    int d12;
    int err_cyc;
    rst_n = 1'b0;
    start = 1'b0;

    // ---- reset and release
    if (AUTO) push_writes(6);
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", busy, AUTO);
    wait_idle("post_rst_idle");

    // ---- run 1: normal sequence, ready tied high, done 20 cycles after accept
    acc_n = 0;
    acc_cyc.delete();
    push_writes(6);
    pulse_start();
    chk("r1_busy_n",  busy,         1'b1);
    chk("r1_done_clr", done,        1'b0);
    chk("r1_req_n",   sif.sccb_req, 1'b0);
    tick();
    chk("r1_req_n1",  sif.sccb_req, 1'b0);
    tick();
    chk("r1_req_n2",  sif.sccb_req, 1'b1);
    chk("r1_id_n2",   sif.sccb_id,  8'h42);
    chk("r1_addr_n2", sif.sccb_addr, 8'h12);
    chk("r1_data_n2", sif.sccb_data, 8'h80);
    wait_done("r1_done");
    chk("r1_busy_end", busy,      1'b0);
    chk("r1_err_end",  err,       1'b0);
    chk("r1_idx_end",  entry_idx, 3'd7);
    chk("r1_nwrites",  acc_n,     6);
    chk("r1_sb_empty", sb_q.size(), 0);
    d01 = (acc_cyc.size() >= 3) ? acc_cyc[1] - acc_cyc[0] : -1;
    d12 = (acc_cyc.size() >= 3) ? acc_cyc[2] - acc_cyc[1] : -1;
    // 20 to done + FETCH + 100 DELAY + FETCH + REQ setup + accept
    chk("r1_gap_delay", d01, 124);
    chk("r1_gap_plain", d12, 23);

    // ---- run 2: backpressure, spurious done in REQ, start while busy
    bp = 1'b1;
    spur = 1'b1;
    acc_n = 0;
    acc_cyc.delete();
    push_writes(6);
    pulse_start();
    chk("r2_busy", busy, 1'b1);
    repeat (40) tick();
    pulse_start();
    chk("r2_busy_ign", busy, 1'b1);
    repeat (60) tick();
    pulse_start();
    wait_done("r2_done");
    chk("r2_nwrites",  acc_n,       6);
    chk("r2_sb_empty", sb_q.size(), 0);
    chk("r2_err",      err,         1'b0);
    d12 = (acc_cyc.size() >= 3) ? acc_cyc[2] - acc_cyc[1] : -1;
    chk("r2_gap_bp", d12, 30);
    bp = 1'b0;
    spur = 1'b0;

    // ---- run 3: timeout on entry 3 (third write), then restart
    kill_no = 2;
    acc_n = 0;
    acc_cyc.delete();
    push_writes(3);
    pulse_start();
    for (int i = 0; i < 2000 && !err; i++) tick();
    err_cyc = ncyc;
    chk("r3_err",      err,       1'b1);
    chk("r3_busy",     busy,      1'b0);
    chk("r3_done",     done,      1'b0);
    chk("r3_idx",      entry_idx, 3'd3);
    chk("r3_sb_empty", sb_q.size(), 0);
    chk("r3_tmo_lat",  (acc_cyc.size() >= 3) ? err_cyc - acc_cyc[2] : -1, 65);
    kill_no = -1;
    acc_n = 0;
    acc_cyc.delete();
    push_writes(6);
    pulse_start();
    chk("r3_err_clr", err,       1'b0);
    chk("r3_rbusy",   busy,      1'b1);
    chk("r3_ridx",    entry_idx, 3'd0);
    repeat (2) tick();
    chk("r3_req",  sif.sccb_req,  1'b1);
    chk("r3_addr", sif.sccb_addr, 8'h12);
    chk("r3_data", sif.sccb_data, 8'h80);
    wait_done("r3_rdone");
    chk("r3_nwrites", acc_n, 6);

    // ---- run 4: done lands on the final timeout cycle
    done_lat = 64;
    acc_n = 0;
    push_writes(6);
    pulse_start();
    wait_done("r4_done");
    chk("r4_err",      err,       1'b0);
    chk("r4_idx",      entry_idx, 3'd7);
    chk("r4_nwrites",  acc_n,     6);
    chk("r4_sb_empty", sb_q.size(), 0);
    done_lat = 20;

    // ---- run 5: reset while waiting for done on entry 4
    acc_n = 0;
    push_writes(4);
    pulse_start();
    for (int i = 0; i < 2000 && acc_n < 4; i++) tick();
    repeat (5) tick();
    chk("r5_idx_pre",  entry_idx,   3'd4);
    chk("r5_busy_pre", busy,        1'b1);
    chk("r5_sb_empty", sb_q.size(), 0);
    if (AUTO) push_writes(6);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("r5_rst");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("r5_busy_rel", busy, AUTO);
    wait_idle("r5_idle");
    acc_n = 0;
    push_writes(6);
    pulse_start();
    wait_done("r5_done");
    chk("r5_nwrites", acc_n, 6);
    chk("r5_sb_end",  sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sccb_init_seq.md
# sccb_init_seq

Camera register-initialisation sequencer that sits directly upstream of the SCCB write controller. It steps through a fixed table of OV7670 register/value pairs and issues one SCCB write per entry over a request/ready/done handshake. It inserts a settle delay after the soft reset, and reports completion or a timeout error to the rest of the camera pipeline.

## Interface
Parameters:
- SLAVE_ID, 8'h42, SCCB write device ID driven on every request
- DELAY_CYCLES, 24'd240000, settle delay in xclk cycles after the soft-reset write (10 ms at 24 MHz)
- TIMEOUT_CYCLES, 16'd50000, maximum xclk cycles from accepted request to sccb_done

Ports:
- xclk  in  1  system/camera clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; (re)runs the sequence from entry 0
- sccb_req  out  1  write request to the SCCB controller
- sccb_ready  in  1  controller can accept a request this cycle
- sccb_id  out  8  device ID (SLAVE_ID while sccb_req=1, else 0)
- sccb_addr  out  8  register address
- sccb_data  out  8  register value
- sccb_done  in  1  one-cycle pulse when the controller finishes the write
- busy  out  1  sequence in progress
- done  out  1  sequence finished successfully; held
- err  out  1  timeout occurred; held
- entry_idx  out  3  current table index

## Operation
- Table, indexed 0..7, with each entry holding {addr, data}:
  - 0: {0x12,0x80}
  - 1: DELAY marker
  - 2: {0x12,0x14}
  - 3: {0x40,0xD0}
  - 4: {0x11,0x01}
  - 5: {0x3A,0x04}
  - 6: {0x8C,0x00}
  - 7: END marker
- States: IDLE, FETCH, REQ, WAIT, DELAY, DONE, ERR.
- IDLE: waits for start, then moves to FETCH with entry_idx=0 and busy=1.
- FETCH: decodes the entry at entry_idx.
  - Write entry: latch addr/data and go to REQ.
  - DELAY entry: clear the delay counter and go to DELAY.
  - END entry: go to DONE.
- REQ: sccb_req=1, with id/addr/data stable. A transfer occurs on the cycle where sccb_req and sccb_ready are both 1. On that cycle go to WAIT and clear the timeout counter; sccb_req deasserts on the next cycle.
- WAIT: the timeout counter increments every cycle.
  - sccb_done=1: entry_idx+1, then FETCH.
  - Counter reaches TIMEOUT_CYCLES-1 without done: go to ERR.
  - If done and expiry land in the same cycle, done wins.
- DELAY: the counter increments. When it reaches DELAY_CYCLES-1, entry_idx+1, then FETCH. No SCCB traffic occurs during DELAY.
- DONE: done=1 and busy=0. entry_idx stays at 7.
- ERR: err=1 and busy=0. entry_idx holds the failing entry.
- start in DONE or ERR clears done and err and restarts at entry 0.
- start while busy=1 is ignored.
- sccb_done outside WAIT is ignored.
- sccb_ready outside REQ is ignored.
- Counters are unsigned and saturate at their terminal value; they never wrap.
- Reset, including mid-transfer, does the following:
  - State returns to IDLE.
  - sccb_req=0, sccb_id/addr/data=0.
  - busy=0, done=0, err=0, entry_idx=0.
  - Any transfer the controller has already accepted completes on its own; the sequencer does not track it.

## Timing
- start sampled high at edge N: busy=1 after edge N, FETCH during cycle N+1, sccb_req=1 after edge N+2.
- Handshake accepted at edge A: sccb_req=0 after edge A.
- sccb_done at edge D: next sccb_req=1 after edge D+2 (via FETCH, REQ).
- DELAY entry: exactly DELAY_CYCLES cycles in DELAY, plus one FETCH cycle on each side.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SCCB_INIT_AUTOSTART_EN:
  - Defined: leaving reset behaves as an internal start pulse on the first edge after rst_n deasserts. The sequence runs without an external start; the start input still restarts from DONE/ERR.
  - Undefined: the block stays in IDLE until start.

## Test plan
- Normal run, sccb_ready tied 1, controller model pulses sccb_done 20 cycles after each accept, DELAY_CYCLES=100 -> exactly 6 writes in order (0x12/0x80, 0x12/0x14, 0x40/0xD0, 0x11/0x01, 0x3A/0x04, 0x8C/0x00), all with id 0x42; a 100-cycle gap with sccb_req=0 after the first write; then done=1, busy=0.
- Backpressure, sccb_ready low for 7 cycles per request -> sccb_req and addr/data held stable throughout; exactly one accept per entry.
- Timeout, TIMEOUT_CYCLES=64, model never pulses done on entry 3 -> err=1 exactly 64 cycles after accept, entry_idx=3, busy=0; then start -> err clears and write 0x12/0x80 reissued.
- Tie, sccb_done coincident with the final timeout cycle -> no err; entry advances.
- Reset mid-WAIT (rst_n low for 1 cycle during entry 4) -> all outputs at reset values immediately; the sequence restarts only on start, or automatically with SCCB_INIT_AUTOSTART_EN.
- start pulsed while busy, plus spurious sccb_done in REQ -> both ignored; write order unchanged.
